// File: rtl/bft_pkg.sv
// BFT packet layout shared by leaf-side blocks: field widths/offsets, the
// header builder and the transmit-stage FSM states.
package bft_pkg;
    localparam int PKT_W     = 49;
    localparam int PAYLOAD_W = 32;
    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;

    localparam int VALID_BIT   = 48;
    localparam int LEAF_LSB    = 43;
    localparam int PORT_LSB    = 39;
    localparam int ADDR_LSB    = 32;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [0:0] {
        ST_UNCFG  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic [PKT_W-1:0] build_packet(
        input logic [LEAF_W-1:0]    leaf,
        input logic [PORT_W-1:0]    port,
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[VALID_BIT]                       = 1'b1;
        p[LEAF_LSB +: LEAF_W]              = leaf;
        p[PORT_LSB +: PORT_W]              = port;
        p[ADDR_LSB +: ADDR_W]              = addr;
        p[PAYLOAD_LSB +: PAYLOAD_W]        = payload;
        return p;
    endfunction
endpackage

// File: rtl/leaf_out_packetizer_if.sv
// User-stream and arbiter-side handshake bundle of the leaf output packetizer.
interface leaf_out_packetizer_if #(
    parameter int PACKET_BITS  = bft_pkg::PKT_W,
    parameter int PAYLOAD_BITS = bft_pkg::PAYLOAD_W
);
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;
    logic [PACKET_BITS-1:0]  dout_packet;
    logic                    vld_packet;
    logic                    ack_packet;

    modport master (
        output din_leaf_user2interface, vld_user2interface, ack_packet,
        input  ack_interface2user, dout_packet, vld_packet
    );
    modport slave (
        input  din_leaf_user2interface, vld_user2interface, ack_packet,
        output ack_interface2user, dout_packet, vld_packet
    );
endinterface

// File: rtl/pkt_skid_fifo2.sv
// Two-entry fully registered FIFO; outputs come only from flops so neither
// side sees a combinational path from the other.
module pkt_skid_fifo2
    import bft_pkg::*;
#(
    parameter int WIDTH = PKT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);
    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_q, wr_d, rd_q, rd_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    // A full FIFO can still take a word in the same cycle its head leaves.
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
        end
        if (do_pop)
            rd_d = ~rd_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q == 2'd2);
    assign vld  = (cnt_q != 2'd0);
    assign dout = mem_q[rd_q];
endmodule

// File: rtl/leaf_out_packetizer.sv
// Per-port transmit stage: wraps user words into BFT packets, gates on
// destination credits and buffers two packets toward the output arbiter.
module leaf_out_packetizer
    import bft_pkg::*;
#(
    parameter int PACKET_BITS           = PKT_W,
    parameter int PAYLOAD_BITS          = PAYLOAD_W,
    parameter int NUM_LEAF_BITS         = LEAF_W,
    parameter int NUM_PORT_BITS         = PORT_W,
    parameter int NUM_ADDR_BITS         = ADDR_W,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          ap_rst_n,
    input  logic                          cfg_vld,
    input  logic [NUM_LEAF_BITS-1:0]      cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cfg_dest_port,
    input  logic                          freespace_upd,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit_cnt,
    output logic                          credit_err,
    leaf_out_packetizer_if.slave          bus
);
    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(2**NUM_BRAM_ADDR_BITS);
    localparam logic [CW:0] CREDIT_INC = (CW+1)'(FREESPACE_UPDATE_SIZE);

    state_e                   state_q, state_d;
    logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
    logic [NUM_PORT_BITS-1:0] port_q, port_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CW-1:0]            credit_q, credit_d;
    logic                     err_q, err_d;
    logic [CW:0]              credit_sum;
    logic                     ready, xfer, fifo_full;
    logic [PACKET_BITS-1:0]   pkt;

    // Ready depends on flops only, never on the user valid or arbiter ack.
    assign ready = (state_q == ST_ACTIVE) && (credit_q != '0) && !fifo_full;
    assign xfer  = ready && bus.vld_user2interface;
    assign pkt   = build_packet(leaf_q, port_q, addr_q, bus.din_leaf_user2interface);

    always_comb begin
        state_d = state_q;
        leaf_d  = leaf_q;
        port_d  = port_q;
        addr_d  = addr_q;
        if (xfer)
            addr_d = addr_q + NUM_ADDR_BITS'(1);
        // A coincident transfer has already used the old header above.
        if (cfg_vld) begin
            state_d = ST_ACTIVE;
            leaf_d  = cfg_dest_leaf;
            port_d  = cfg_dest_port;
            addr_d  = '0;
        end

        err_d      = err_q;
        credit_sum = {1'b0, credit_q} + (freespace_upd ? CREDIT_INC : '0) - (CW+1)'(xfer);
        credit_d   = credit_sum[CW-1:0];
        if (credit_sum > CREDIT_MAX) begin
            credit_d = CREDIT_MAX[CW-1:0];
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_UNCFG;
            leaf_q   <= '0;
            port_q   <= '0;
            addr_q   <= '0;
            credit_q <= CREDIT_MAX[CW-1:0];
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            leaf_q   <= leaf_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    pkt_skid_fifo2 #(.WIDTH(PACKET_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (ap_rst_n),
        .push  (xfer),
        .din   (pkt),
        .full  (fifo_full),
        .pop   (bus.ack_packet),
        .dout  (bus.dout_packet),
        .vld   (bus.vld_packet)
    );

    assign bus.ack_interface2user = ready;
    assign credit_cnt             = credit_q;
    assign credit_err             = err_q;
endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed and randomized bench for leaf_out_packetizer against a queue-based
// transaction model of packets, credits and configuration.
module tb_leaf_out_packetizer;
    logic       clk = 1'b0;
    logic       ap_rst_n;
    logic       cfg_vld;
    logic [4:0] cfg_dest_leaf;
    logic [3:0] cfg_dest_port;
    logic       freespace_upd;
    logic [7:0] credit_cnt;
    logic       credit_err;

    int checks = 0;
    int errors = 0;

    leaf_out_packetizer_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32)) bus ();

    leaf_out_packetizer dut (
        .clk           (clk),
        .ap_rst_n      (ap_rst_n),
        .cfg_vld       (cfg_vld),
        .cfg_dest_leaf (cfg_dest_leaf),
        .cfg_dest_port (cfg_dest_port),
        .freespace_upd (freespace_upd),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Reference model: configuration, credit count and buffered packets.
    bit          m_active;
    int          m_leaf, m_port, m_addr, m_credit;
    bit          m_err;
    logic [48:0] m_q[$];
    int          dut_acc, dut_pop;

    function automatic logic [48:0] mpkt(input int leaf, input int port, input int addr,
                                         input logic [31:0] d);
        logic [48:0] p;
        p = {1'b1, leaf[4:0], port[3:0], addr[6:0], d};
        return p;
    endfunction

    function automatic bit m_ready();
        return m_active && (m_credit > 0) && (m_q.size() < 2);
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_leaf   = 0;
        m_port   = 0;
        m_addr   = 0;
        m_credit = 128;
        m_err    = 1'b0;
        m_q.delete();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ack",    64'(bus.ack_interface2user), 64'(m_ready()));
        chk("vld",    64'(bus.vld_packet),         64'(m_q.size() > 0));
        if (m_q.size() > 0)
            chk("dout", 64'(bus.dout_packet), 64'(m_q[0]));
        chk("credit", 64'(credit_cnt), 64'(m_credit));
        chk("err",    64'(credit_err), 64'(m_err));
    endtask

    task automatic idle_inputs();
        cfg_vld                     = 1'b0;
        cfg_dest_leaf               = '0;
        cfg_dest_port               = '0;
        freespace_upd               = 1'b0;
        bus.vld_user2interface      = 1'b0;
        bus.din_leaf_user2interface = '0;
        bus.ack_packet              = 1'b0;
    endtask

    // One clock: drive at the negedge, check, advance the model, wait a cycle.
    task automatic cycle(input bit cv, input int cl, input int cp, input bit fu,
                         input bit v, input logic [31:0] d, input bit ap);
        bit xfer;
        int c;
        logic [48:0] dummy;
        cfg_vld                     = cv;
        cfg_dest_leaf               = 5'(cl);
        cfg_dest_port               = 4'(cp);
        freespace_upd               = fu;
        bus.vld_user2interface      = v;
        bus.din_leaf_user2interface = d;
        bus.ack_packet              = ap;
        check_outputs();
        if (v && bus.ack_interface2user) dut_acc++;
        if (ap && bus.vld_packet)        dut_pop++;

        xfer = v && m_ready();
        if (ap && m_q.size() > 0) dummy = m_q.pop_front();
        if (xfer) m_q.push_back(mpkt(m_leaf, m_port, m_addr, d));
        if (cv) begin
            m_active = 1'b1;
            m_leaf   = cl;
            m_port   = cp;
            m_addr   = 0;
        end else if (xfer) begin
            m_addr = (m_addr + 1) % 128;
        end
        c = m_credit + (fu ? 64 : 0) - (xfer ? 1 : 0);
        if (c > 128) begin
            c     = 128;
            m_err = 1'b1;
        end
        m_credit = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; effects must be immediate.
    task automatic do_reset();
        #2 ap_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_dout", 64'(bus.dout_packet), 64'(0));
        idle_inputs();
        @(negedge clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w0;
        idle_inputs();
        model_reset();
        ap_rst_n = 1'b0;
        @(negedge clk);
        check_outputs();
        chk("rst_dout", 64'(bus.dout_packet), 64'(0));
        @(negedge clk);
        ap_rst_n = 1'b1;

        // Unconfigured: never ready, never emits.
        repeat (20) cycle(0, 0, 0, 0, 1, $urandom, 1);

        // Configure leaf 11 port 3, three words with one-cycle latency.
        cycle(1, 11, 3, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 1, 32'hA, 1);
        chk("pkt_a", 64'(bus.dout_packet), 64'({1'b1, 5'd11, 4'd3, 7'd0, 32'hA}));
        cycle(0, 0, 0, 0, 1, 32'hB, 1);
        chk("pkt_b", 64'(bus.dout_packet), 64'({1'b1, 5'd11, 4'd3, 7'd1, 32'hB}));
        cycle(0, 0, 0, 0, 1, 32'hC, 1);
        chk("pkt_c", 64'(bus.dout_packet), 64'({1'b1, 5'd11, 4'd3, 7'd2, 32'hC}));
        cycle(0, 0, 0, 0, 0, 32'h0, 1);

        // Credit exhaustion and replenish.
        do_reset();
        cycle(1, 2, 1, 0, 0, 32'h0, 1);
        dut_acc = 0;
        repeat (135) cycle(0, 0, 0, 0, 1, $urandom, 1);
        chk("acc128",     64'(dut_acc), 64'(128));
        chk("credit0",    64'(credit_cnt), 64'(0));
        chk("stall_ack",  64'(bus.ack_interface2user), 64'(0));
        cycle(0, 0, 0, 1, 0, 32'h0, 1);
        chk("credit64",   64'(credit_cnt), 64'(64));
        chk("resume_ack", 64'(bus.ack_interface2user), 64'(1));
        repeat (3) cycle(0, 0, 0, 0, 1, $urandom, 1);

        // Back-pressure: two words held, head stable, then drained in order.
        do_reset();
        cycle(1, 17, 6, 0, 0, 32'h0, 0);
        w0 = $urandom;
        cycle(0, 0, 0, 0, 1, w0, 0);
        repeat (4) cycle(0, 0, 0, 0, 1, $urandom, 0);
        chk("hold_dout", 64'(bus.dout_packet), 64'(mpkt(17, 6, 0, w0)));
        chk("full_ack",  64'(bus.ack_interface2user), 64'(0));
        dut_pop = 0;
        repeat (4) cycle(0, 0, 0, 0, 0, 32'h0, 1);
        chk("drain2",    64'(dut_pop), 64'(2));

        // Credit overflow sets a sticky error.
        do_reset();
        cycle(1, 4, 2, 0, 0, 32'h0, 1);
        repeat (28) cycle(0, 0, 0, 0, 1, $urandom, 1);
        chk("credit100", 64'(credit_cnt), 64'(100));
        cycle(0, 0, 0, 1, 0, 32'h0, 1);
        chk("sat128",    64'(credit_cnt), 64'(128));
        chk("err_set",   64'(credit_err), 64'(1));
        repeat (5) cycle(0, 0, 0, 0, 1, $urandom, 1);
        chk("err_stick", 64'(credit_err), 64'(1));

        // Reconfigure coincident with the transfer at address 5.
        do_reset();
        cycle(1, 7, 9, 0, 0, 32'h0, 1);
        repeat (5) cycle(0, 0, 0, 0, 1, $urandom, 1);
        cycle(1, 20, 12, 0, 1, 32'h5555, 1);
        chk("old_hdr", 64'(bus.dout_packet), 64'({1'b1, 5'd7, 4'd9, 7'd5, 32'h5555}));
        cycle(0, 0, 0, 0, 1, 32'h6666, 1);
        chk("new_hdr", 64'(bus.dout_packet), 64'({1'b1, 5'd20, 4'd12, 7'd0, 32'h6666}));

        // Reset with two packets buffered drops them at once.
        repeat (3) cycle(0, 0, 0, 0, 1, $urandom, 0);
        chk("pre_rst_vld", 64'(bus.vld_packet), 64'(1));
        do_reset();

        // Randomized traffic with occasional reconfig and updates.
        cycle(1, 9, 5, 0, 0, 32'h0, 1);
        repeat (400)
            cycle($urandom_range(0, 49) == 0, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 15)), $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
